spike_event_tx: RTL and testbench

- Transmit end of the spike-output link from the token network to the off-chip host.
- Buffers spike events (emitting neuron index) produced by the network/processor cores in a small FIFO.
- Presents each event on the output pins with a 4-phase req/ack handshake against an asynchronous host acknowledge.
- Sits between the network's event output and the top-level uo_out/uio pins; it is the counterpart of the host-to-chip token receiver.

---
 rtl/spike_event_tx_pkg.sv | 12 +
 rtl/spike_event_tx_sync_fifo.sv | 50 +++++
 rtl/spike_event_tx.sv | 103 ++++++++++
 tb/tb_spike_event_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_event_tx_pkg.sv
// Shared definitions for the spike event link: handshake states and the default event width.
package spike_event_tx_pkg;

    localparam int DEF_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_e;

endpackage

// File: rtl/spike_event_tx_sync_fifo.sv
// Single-clock FIFO with free-running wrapping pointers and a separate occupancy counter.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guarded here too so a careless caller can never corrupt the occupancy.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spike_event_tx.sv
// Spike event transmitter: buffers neuron indices and hands them to the host over a 4-phase req/ack link.
module spike_event_tx
    import spike_event_tx_pkg::*;
#(
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          event_valid_in,
    input  logic [ID_WIDTH-1:0]           event_id_in,
    output logic                          event_ready_out,
    input  logic                          ack_in,
    output logic                          req_out,
    output logic [ID_WIDTH-1:0]           data_out,
    output logic                          overflow_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    hs_state_e           state_q, state_d;
    logic                req_q, req_d;
    logic [ID_WIDTH-1:0] data_q, data_d;
    logic                overflow_q;
    logic                ack_meta_q, ack_s_q;

    logic                fifo_full, fifo_empty, push, pop;
    logic [ID_WIDTH-1:0] fifo_head;

    assign event_ready_out = !fifo_full;
    assign push            = event_valid_in && event_ready_out;

    sync_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (event_id_in),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ack_meta_q <= ack_in;
            ack_s_q    <= ack_meta_q;
            overflow_q <= overflow_q | (event_valid_in & fifo_full);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    // A stale ack still high in IDLE blocks new requests until the host lowers it.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !ack_s_q) begin
                    data_d  = fifo_head;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s_q) begin
                    pop     = 1'b1;
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_out      = req_q;
    assign data_out     = data_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_spike_event_tx.sv
// Directed bench for spike_event_tx with a cycle-level protocol model checked on every falling edge.
module tb_spike_event_tx;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         event_valid_in = 1'b0;
    logic [W-1:0] event_id_in = '0;
    logic         event_ready_out;
    logic         ack_in = 1'b0;
    logic         req_out;
    logic [W-1:0] data_out;
    logic         overflow_out;
    logic [$clog2(D):0] fifo_count_out;

    int tests = 0;
    int fails = 0;

    spike_event_tx #(.ID_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .event_valid_in (event_valid_in),
        .event_id_in    (event_id_in),
        .event_ready_out(event_ready_out),
        .ack_in         (ack_in),
        .req_out        (req_out),
        .data_out       (data_out),
        .overflow_out   (overflow_out),
        .fifo_count_out (fifo_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: queue of accepted events, host ack seen two edges late, phase of the handshake.
    logic [W-1:0] mq[$];
    int           m_phase = 0;      // 0 idle, 1 request outstanding, 2 waiting for ack low
    bit           m_s1 = 0, m_s2 = 0, m_req = 0, m_ovf = 0, m_pop, m_full;
    logic [W-1:0] m_data = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_req = 0; m_ovf = 0; m_data = '0;
        end else begin
            m_pop  = 0;
            m_full = (mq.size() == D);
            case (m_phase)
                0: if (mq.size() != 0 && !m_s2) begin m_data = mq[0]; m_req = 1; m_phase = 1; end
                1: if (m_s2) begin m_pop = 1; m_req = 0; m_phase = 2; end
                default: if (!m_s2) m_phase = 0;
            endcase
            if (event_valid_in && m_full) m_ovf = 1;
            if (m_pop) void'(mq.pop_front());
            if (event_valid_in && !m_full) mq.push_back(event_id_in);
            m_s2 = m_s1;
            m_s1 = ack_in;
        end
    end

    logic [W-1:0] emitted[$];
    bit           prev_req = 0;

    always @(negedge clk) begin
        chk("req", req_out, m_req);
        chk("data", data_out, m_data);
        chk("count", fifo_count_out, mq.size());
        chk("ready", event_ready_out, mq.size() != D);
        chk("overflow", overflow_out, m_ovf);
        if (req_out && !prev_req) emitted.push_back(data_out);
        prev_req = req_out;
    end

    // Host: raises ack one cycle after seeing req, lowers it one cycle after req falls.
    bit host_en = 0;
    always @(posedge clk) begin
        #1;
        if (host_en) ack_in = req_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (fifo_count_out == 0 && !req_out && m_phase == 0 && !m_s2 && !ack_in) done = 1;
        end
        chk("wait_idle_timeout", done, 1);
    endtask

    task automatic check_seq(input string name, input logic [W-1:0] exp[$]);
        chk({name, "_len"}, emitted.size(), exp.size());
        for (int i = 0; i < exp.size() && i < emitted.size(); i++)
            chk(name, emitted[i], exp[i]);
    endtask

    initial begin
        logic [W-1:0] ids[$];
        int n, sent, simul;
        bit sim_pending, got;

        // Reset with ack and valid high
        event_valid_in = 1; event_id_in = 4'hF; ack_in = 1;
        repeat (3) tick();
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_count", fifo_count_out, 0);
        chk("rst_ready", event_ready_out, 1);
        reset = 0; event_valid_in = 0;
        repeat (2) tick();
        event_valid_in = 1; event_id_in = 4'h7;
        tick();
        event_valid_in = 0;
        repeat (4) tick();
        chk("stale_ack_blocks_req", req_out, 0);
        ack_in = 0;
        repeat (3) tick();
        chk("req_after_ack_low", req_out, 1);
        chk("req_after_ack_low_data", data_out, 4'h7);
        host_en = 1;
        wait_idle(50);
        ids = '{4'h7};
        check_seq("seq_first", ids);
        emitted.delete();

        // Single event
        event_valid_in = 1; event_id_in = 4'h5;
        tick();
        event_valid_in = 0;
        chk("single_no_req_yet", req_out, 0);
        chk("single_count", fifo_count_out, 1);
        tick();
        chk("single_req", req_out, 1);
        chk("single_data", data_out, 4'h5);
        n = 0;
        do begin tick(); n++; end while (req_out && n < 10);
        chk("single_ack_to_drop", n, 3);
        wait_idle(50);
        chk("single_count_end", fifo_count_out, 0);
        ids = '{4'h5};
        check_seq("seq_single", ids);
        emitted.delete();

        // Burst with host stalled, then overflow
        host_en = 0; ack_in = 0;
        for (int i = 1; i <= 4; i++) begin
            event_valid_in = 1; event_id_in = W'(i);
            tick();
        end
        chk("burst_count", fifo_count_out, 4);
        chk("burst_ready", event_ready_out, 0);
        event_id_in = 4'hA;
        tick();
        event_valid_in = 0;
        chk("ovf_set", overflow_out, 1);
        chk("ovf_count", fifo_count_out, 4);
        host_en = 1;
        wait_idle(200);
        chk("ovf_sticky", overflow_out, 1);
        ids = '{4'h1, 4'h2, 4'h3, 4'h4};
        check_seq("seq_burst", ids);
        emitted.delete();

        // Simultaneous push/pop keeping two entries queued
        ids.delete();
        for (int i = 0; i < 10; i++) ids.push_back(W'((i * 3 + 1) % 16));
        event_valid_in = 1; event_id_in = ids[0]; tick();
        event_id_in = ids[1]; tick();
        event_valid_in = 0;
        sent = 2; simul = 0; sim_pending = 0;
        for (int c = 0; c < 400 && sent < 10; c++) begin
            if (m_phase == 1 && m_s2) begin
                event_valid_in = 1; event_id_in = ids[sent]; sent++; sim_pending = 1;
            end else begin
                event_valid_in = 0;
            end
            tick();
            if (sim_pending) begin
                chk("simul_count", fifo_count_out, 2);
                simul++;
                sim_pending = 0;
            end
        end
        event_valid_in = 0;
        chk("simul_edges", simul, 8);
        wait_idle(300);
        check_seq("seq_wrap", ids);
        emitted.delete();

        // Reset in the middle of a request
        host_en = 0; ack_in = 0;
        for (int i = 0; i < 3; i++) begin
            event_valid_in = 1; event_id_in = W'(4'h2 + 4'h4 * i);
            tick();
        end
        event_valid_in = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (req_out) got = 1; else tick();
        end
        chk("midrst_req_seen", got, 1);
        chk("midrst_queued", fifo_count_out, 3);
        reset = 1;
        #1;
        chk("midrst_req_drop", req_out, 0);
        chk("midrst_count", fifo_count_out, 0);
        chk("midrst_ready", event_ready_out, 1);
        emitted.delete();
        tick(); tick();
        reset = 0;
        repeat (10) tick();
        chk("midrst_no_req", req_out, 0);
        chk("midrst_no_emit", emitted.size(), 0);
        chk("midrst_ovf_clear", overflow_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
